fcs_crc_engine: RTL and testbench
=================================

# fcs_crc_engine

Parametrised Ethernet FCS engine that folds `BYTES` octets per cycle into a reflected CRC-32 and checks frame length, generalising the byte-serial `crc32_next` usage to wide datapaths. It sits on the rx path after preamble/SFD stripping to flag FCS and length errors. Optionally, it also sits on the tx path to append the 4-byte FCS after the last payload beat.

## Interface
- `BYTES`, 1: octets per beat; legal values are 1, 2, 4 and 8.
- `MIN_FRAME`, 64: minimum legal frame length in bytes, DA through FCS.
- `MAX_FRAME`, 1518: maximum legal frame length in bytes.
- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: beat valid.
- `in_ready` output 1: beat accepted when `in_valid && in_ready`.
- `in_data` input 8*BYTES: byte k is `[8k+7:8k]`; byte 0 is first on the wire.
- `in_keep` input BYTES: valid bytes; contiguous from bit 0; honoured only on `in_eof` beats.
- `in_sof` input 1: first beat of a frame.
- `in_eof` input 1: last beat of a frame.
- `crc_out` output 32: complemented running CRC, i.e. the FCS of the bytes accepted so far.
- `done` output 1: one-cycle pulse when a frame completes.
- `crc_ok` output 1: CRC residue matched; valid from `done` until the next `in_sof` is accepted.
- `len_err` output 1: frame length < `MIN_FRAME` or > `MAX_FRAME`; same validity window as `crc_ok`.
- `frame_len` output 11: bytes accepted in the frame; saturates at 2047.
- `fcs_valid`, `fcs_ready`, `fcs_byte[7:0]`: append port; present only with `FCS_CRC_APPEND_EN`.

## Operation
- CRC arithmetic:
  - Polynomial: reflected 32'hEDB88320, shifting right, LSB first.
  - Initial register value: 32'hFFFFFFFF.
  - Byte fold: one byte per `crc32` step, applied in order for bytes 0..n-1 of the beat within a single cycle.
  - `crc_out` = ~register.
- Check mode: the internal register after data + received FCS must equal the residue 32'hDEBB20E3. This is the bit-reverse of 32'hC704DD7B.
- States: IDLE, ACCUM, and APPEND (APPEND exists only with the macro).
- IDLE:
  - An accepted beat with `in_sof` loads the init value, folds the beat, sets `frame_len` = bytes in the beat, and moves to ACCUM.
  - An accepted beat with `in_sof && in_eof` completes in the same beat.
  - A beat without `in_sof` is accepted and discarded.
- ACCUM:
  - Each beat folds its bytes and adds them to `frame_len`.
  - An `in_eof` beat folds only the `in_keep` bytes and then returns to IDLE (or goes to APPEND).
  - An `in_eof` beat with `in_keep`==0 adds no bytes.
- `in_sof` while in ACCUM: the current frame is aborted with no `done`, and a new frame starts from this beat.
- Status on completion, registered:
  - `crc_ok` = (register == residue).
  - `len_err` = length violation.
  - `done` pulses.
- Reset, including mid-frame: the block goes to IDLE and the frame in progress is lost.
- Reset values: `in_ready`=1, `crc_out`=32'h00000000, `done`=0, `crc_ok`=0, `len_err`=0, `frame_len`=0, `fcs_valid`=0, `fcs_byte`=0.

## Timing
- `crc_out` and `frame_len` update in the cycle after the accepting edge.
- `done`, `crc_ok` and `len_err` are asserted in the cycle after the `in_eof` beat is accepted.
- Throughput: one beat per cycle in check mode; `in_ready` is constant 1 without the macro.
- Back-to-back frames: an `in_sof` beat in the cycle immediately after an `in_eof` beat is accepted. Its status overwrites the previous frame's status one cycle after its own `in_eof`.

## Configuration
- `FCS_CRC_APPEND_EN` defined: after the `in_eof` beat, the block enters APPEND.
  - `in_ready`=0 throughout APPEND.
  - `fcs_byte` presents `crc_out[7:0]`, `[15:8]`, `[23:16]`, `[31:24]` in that order, each held until `fcs_valid && fcs_ready`.
  - `fcs_valid` rises in the cycle after the `in_eof` beat.
  - After the 4th handshake the block returns to IDLE; `done` pulses at that point.
  - `frame_len` includes the 4 appended bytes, and `len_err` is evaluated on that total.
  - `crc_ok` reads 1 after a completed append.
- `FCS_CRC_APPEND_EN` undefined: the append port and the APPEND state are absent; the block is check-only.

## Test plan
- **Standard check value.** BYTES=1, ASCII "123456789", sof on '1', eof on '9' -> `crc_out`=32'hCBF43926, `frame_len`=9, `len_err`=1, `crc_ok`=0.
- **Wide datapath with FCS.** BYTES=4, "123456789" followed by bytes 26 39 F4 CB (13 bytes), last beat `in_keep`=4'b0001 -> `crc_ok`=1, `frame_len`=13, `done` one cycle after eof.
- **Minimum frame, good and bad.** 60 zero bytes plus correct FCS -> `crc_ok`=1, `len_err`=0, `frame_len`=64. Flip bit 0 of byte 10 -> `crc_ok`=0.
- **Abort mid-frame.** `in_sof` mid-frame after 20 bytes, then a valid 64-byte frame -> exactly one `done`, and `crc_ok`=1. Separately, `rst_n` low mid-frame -> all outputs return to their reset values.
- **Giant frame.** 1519-byte frame with correct FCS -> `len_err`=1, `crc_ok`=1. A 2100-byte frame -> `frame_len`=2047.
- **Append with back-pressure.** `FCS_CRC_APPEND_EN`, payload "123456789", `fcs_ready` toggling 1,0,1,0 -> bytes 26, 39, F4, CB in order, `in_ready`=0 throughout, `done` after the 4th byte, `frame_len`=13.

Source files
------------

// File: rtl/fcs_crc_engine.sv
// fcs_crc_engine
//   Ethernet FCS engine. Folds BYTES octets per beat into a reflected CRC-32
//   (poly 32'hEDB88320, init 32'hFFFFFFFF, LSB first) and checks the frame
//   length. On rx it flags FCS and length errors. When built with the macro
//   FCS_CRC_APPEND_EN it also appends the 4 FCS bytes after the last payload
//   beat, which is the tx use.
//
// Parameters
//   BYTES      octets per beat (1, 2, 4 or 8)
//   MIN_FRAME  minimum legal frame length, DA through FCS
//   MAX_FRAME  maximum legal frame length
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    beat handshake
//   in_data              byte k is [8k+7:8k]; byte 0 is first on the wire
//   in_keep              valid bytes of an in_eof beat, contiguous from bit 0
//   in_sof/in_eof        first/last beat of a frame
//   crc_out              complemented running CRC (FCS of bytes so far)
//   done                 one-cycle pulse at frame completion
//   crc_ok, len_err      frame status, held until the next completion
//   frame_len            bytes in the frame, saturating at 2047
//   fcs_valid/fcs_ready/fcs_byte   append port (FCS_CRC_APPEND_EN only)
module fcs_crc_engine #(
    parameter int BYTES     = 1,
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*BYTES-1:0] in_data,
    input  logic [BYTES-1:0]   in_keep,
    input  logic               in_sof,
    input  logic               in_eof,
    output logic [31:0]        crc_out,
    output logic               done,
    output logic               crc_ok,
    output logic               len_err,
    output logic [10:0]        frame_len
`ifdef FCS_CRC_APPEND_EN
    ,
    output logic               fcs_valid,
    input  logic               fcs_ready,
    output logic [7:0]         fcs_byte
`endif
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME);

`ifdef FCS_CRC_APPEND_EN
    typedef enum logic [1:0] {IDLE, ACCUM, APPEND} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCUM} state_t;
`endif

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    // Bytes 0..n-1 are folded in wire order within one cycle.
    function automatic logic [31:0] crc32_beat(input logic [31:0] c,
                                               input logic [8*BYTES-1:0] d,
                                               input logic [3:0] n);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < BYTES; k++)
            if (k < int'(n)) r = crc32_byte(r, d[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [3:0] keep_count(input logic [BYTES-1:0] k);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < BYTES; i++) n = n + {3'b000, k[i]};
        return n;
    endfunction

    function automatic logic [10:0] sat_add(input logic [10:0] a, input logic [3:0] b);
        logic [11:0] s;
        s = {1'b0, a} + {8'b0, b};
        return s[11] ? 11'h7FF : s[10:0];
    endfunction

    function automatic logic len_bad(input logic [10:0] n);
        return (n < MIN_LEN) || (n > MAX_LEN);
    endfunction

    state_t      state;
    logic [31:0] crc_reg_p1;
    logic        accept;
    logic [3:0]  beat_n;
    logic [31:0] crc_base;
    logic [31:0] crc_next;
    logic [10:0] len_base;
    logic [10:0] len_next;

    assign accept  = in_valid && in_ready;
    assign crc_out = ~crc_reg_p1;

    // in_sof restarts from the init value, which also covers an abort in ACCUM.
    always_comb begin
        beat_n   = in_eof ? keep_count(in_keep) : 4'(BYTES);
        crc_base = in_sof ? CRC_INIT : crc_reg_p1;
        len_base = in_sof ? 11'd0 : frame_len;
        crc_next = crc32_beat(crc_base, in_data, beat_n);
        len_next = sat_add(len_base, beat_n);
    end

`ifdef FCS_CRC_APPEND_EN
    logic [1:0]  fcs_idx;
    logic [31:0] crc_shift;
    logic [10:0] len_final;

    always_comb begin
        crc_shift = crc_out >> {fcs_idx + 2'd1, 3'b000};
        len_final = sat_add(frame_len, 4'd4);
    end
`else
    assign in_ready = 1'b1;
`endif

    // ---- beat accepted -> running CRC, length and status registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            crc_reg_p1 <= CRC_INIT;
            frame_len  <= '0;
            done       <= 1'b0;
            crc_ok     <= 1'b0;
            len_err    <= 1'b0;
`ifdef FCS_CRC_APPEND_EN
            in_ready   <= 1'b1;
            fcs_valid  <= 1'b0;
            fcs_byte   <= '0;
            fcs_idx    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    // Beats outside a frame (no in_sof while IDLE) are dropped.
                    if (accept && (in_sof || state == ACCUM)) begin
                        crc_reg_p1 <= crc_next;
                        frame_len  <= len_next;
                        if (in_eof) begin
`ifdef FCS_CRC_APPEND_EN
                            state     <= APPEND;
                            in_ready  <= 1'b0;
                            fcs_valid <= 1'b1;
                            fcs_byte  <= ~crc_next[7:0];
                            fcs_idx   <= '0;
`else
                            state   <= IDLE;
                            done    <= 1'b1;
                            crc_ok  <= (crc_next == CRC_RESIDUE);
                            len_err <= len_bad(len_next);
`endif
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
`ifdef FCS_CRC_APPEND_EN
                APPEND: begin
                    // The register is frozen here; fcs_byte walks crc_out LSB first.
                    if (fcs_valid && fcs_ready) begin
                        if (fcs_idx == 2'd3) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            fcs_valid <= 1'b0;
                            done      <= 1'b1;
                            crc_ok    <= 1'b1;
                            frame_len <= len_final;
                            len_err   <= len_bad(len_final);
                        end else begin
                            fcs_idx  <= fcs_idx + 2'd1;
                            fcs_byte <= crc_shift[7:0];
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcs_crc_engine.sv
// tb_fcs_crc_engine
//   Bench for fcs_crc_engine with a 1-byte and a 4-byte instance. Expected
//   values come from a byte-queue CRC model (MSB-first normal-form CRC-32 on
//   bit-reversed input, reflected at the end) and from frame-level rules.
`timescale 1ns/1ps
module tb_fcs_crc_engine;

`ifdef FCS_CRC_APPEND_EN
    localparam bit APPEND = 1'b1;
`else
    localparam bit APPEND = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] crc;
        logic        ok;
        logic        le;
        logic [10:0] len;
        int          cyc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fcs_ready = 1'b1;

    logic        v4 = 1'b0, s4 = 1'b0, e4 = 1'b0;
    logic [31:0] d4 = '0;
    logic [3:0]  k4 = '0;
    logic        r4, done4, ok4, le4;
    logic [31:0] crc4;
    logic [10:0] len4;

    logic        v1 = 1'b0, s1 = 1'b0, e1 = 1'b0;
    logic [7:0]  d1 = '0;
    logic [0:0]  k1 = '0;
    logic        r1, done1, ok1, le1;
    logic [31:0] crc1;
    logic [10:0] len1;
`ifdef FCS_CRC_APPEND_EN
    logic        fv4, fv1;
    logic [7:0]  fb4, fb1;
`endif

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    rec_t recs[$];

    fcs_crc_engine #(.BYTES(4), .MIN_FRAME(64), .MAX_FRAME(1518)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_data(d4),
        .in_keep(k4), .in_sof(s4), .in_eof(e4), .crc_out(crc4), .done(done4),
        .crc_ok(ok4), .len_err(le4), .frame_len(len4)
`ifdef FCS_CRC_APPEND_EN
        , .fcs_valid(fv4), .fcs_ready(fcs_ready), .fcs_byte(fb4)
`endif
    );

    fcs_crc_engine #(.BYTES(1), .MIN_FRAME(64), .MAX_FRAME(1518)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_data(d1),
        .in_keep(k1), .in_sof(s1), .in_eof(e1), .crc_out(crc1), .done(done1),
        .crc_ok(ok1), .len_err(le1), .frame_len(len1)
`ifdef FCS_CRC_APPEND_EN
        , .fcs_valid(fv1), .fcs_ready(fcs_ready), .fcs_byte(fb1)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (done4 === 1'b1)
            recs.push_back('{crc: crc4, ok: ok4, le: le4, len: len4, cyc: cyc});

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_fcs(input bq_t q);
        logic [31:0] c, f;
        logic        top;
        c = 32'hFFFFFFFF;
        foreach (q[i])
            for (int b = 0; b < 8; b++) begin
                top = c[31] ^ q[i][b];
                c = {c[30:0], 1'b0};
                if (top) c = c ^ 32'h04C11DB7;
            end
        c = ~c;
        for (int i = 0; i < 32; i++) f[i] = c[31 - i];
        return f;
    endfunction

    // {crc_out, crc_ok, len_err, frame_len} expected at done
    function automatic logic [44:0] model(input bq_t q);
        int          n, L;
        logic        ok;
        bq_t         body;
        logic [31:0] tail;
        n = q.size();
        L = APPEND ? n + 4 : n;
        ok = 1'b0;
        if (n >= 4) begin
            for (int i = 0; i < n - 4; i++) body.push_back(q[i]);
            tail = {q[n-1], q[n-2], q[n-3], q[n-4]};
            ok = (ref_fcs(body) == tail);
        end
        if (APPEND) ok = 1'b1;
        return {ref_fcs(q), ok, (L < 64 || L > 1518), 11'((L > 2047) ? 2047 : L)};
    endfunction

    function automatic bq_t with_fcs(input bq_t q);
        logic [31:0] f;
        bq_t         r;
        r = q;
        f = ref_fcs(q);
        for (int i = 0; i < 4; i++) r.push_back(f[8*i +: 8]);
        return r;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t r;
        for (int i = 0; i < n; i++) r.push_back(8'($urandom));
        return r;
    endfunction

    function automatic bq_t ascii_123456789();
        bq_t r;
        for (int c = 1; c <= 9; c++) r.push_back(8'(8'h30 + c));
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic wait_ready4();
        int t = 0;
        while (r4 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if (r4 !== 1'b1) begin
            total++; bad++;
            $display("FAIL in_ready_timeout got=%b want=1", r4);
        end
    endtask

    task automatic drive4(input bq_t q, input bit with_eof, input bit empty_tail,
                          input bit gaps, output int eof_cyc);
        int n, i;
        n = q.size();
        i = 0;
        eof_cyc = -1;
        while (i < n) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                v4 = 1'b0; d4 = $urandom; s4 = 1'($urandom); e4 = 1'($urandom);
                continue;
            end
            d4 = $urandom;
            k4 = '0;
            for (int k = 0; k < 4; k++)
                if (i + k < n) begin d4[8*k +: 8] = q[i+k]; k4[k] = 1'b1; end
            s4 = (i == 0);
            e4 = with_eof && (i + 4 >= n) && !empty_tail;
            if (!e4) k4 = 4'($urandom);
            v4 = 1'b1;
            wait_ready4();
            if (e4) eof_cyc = cyc + 1;
            i += 4;
        end
        if (with_eof && empty_tail) begin
            @(negedge clk);
            d4 = $urandom; k4 = '0; s4 = 1'b0; e4 = 1'b1; v4 = 1'b1;
            wait_ready4();
            eof_cyc = cyc + 1;
        end
    endtask

    task automatic wait_done(input int n, input string name);
        int t = 0;
        while (recs.size() < n && t < 300) begin @(negedge clk); v4 = 1'b0; #1; t++; end
        total++;
        if (recs.size() < n) begin
            bad++;
            $display("FAIL %s done_count got=%0d want=%0d", name, recs.size(), n);
        end
    endtask

    task automatic idle4(input int n);
        repeat (n) begin @(negedge clk); v4 = 1'b0; end
        #1;
    endtask

    task automatic get_rec(output rec_t r);
        r = '{crc: '0, ok: 1'b0, le: 1'b0, len: '0, cyc: -1};
        if (recs.size() > 0) r = recs.pop_front();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({r4, crc4, done4, ok4, le4, len4} !== {1'b1, 32'h0, 3'b000, 11'h0}) begin
            bad++;
            $display("FAIL reset_w4 got=%h want=%h", {r4, crc4, done4, ok4, le4, len4},
                     {1'b1, 32'h0, 3'b000, 11'h0});
        end
        total++;
        if ({r1, crc1, done1, ok1, le1, len1} !== {1'b1, 32'h0, 3'b000, 11'h0}) begin
            bad++;
            $display("FAIL reset_w1 got=%h want=%h", {r1, crc1, done1, ok1, le1, len1},
                     {1'b1, 32'h0, 3'b000, 11'h0});
        end
`ifdef FCS_CRC_APPEND_EN
        total++;
        if ({fv4, fb4} !== 9'h0) begin
            bad++; $display("FAIL reset_fcs got=%h want=000", {fv4, fb4});
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_standard();
        bq_t         q;
        int          t;
        logic [44:0] exp;
        q = ascii_123456789();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            v1 = 1'b1; d1 = q[i]; k1 = 1'b1; s1 = (i == 0); e1 = (i == 8);
        end
        @(negedge clk);
        v1 = 1'b0; s1 = 1'b0; e1 = 1'b0;
        #1;
        t = 0;
        while (done1 !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
        total++;
        if (t !== (APPEND ? 4 : 0)) begin
            bad++; $display("FAIL std_done_latency got=%0d want=%0d", t, APPEND ? 4 : 0);
        end
        total++;
        if (crc1 !== 32'hCBF43926) begin
            bad++; $display("FAIL std_crc got=%h want=cbf43926", crc1);
        end
        exp = model(q);
        total++;
        if ({crc1, ok1, le1, len1} !== exp) begin
            bad++; $display("FAIL std_status got=%h want=%h", {crc1, ok1, le1, len1}, exp);
        end
    endtask

    task automatic test_wide_fcs();
        bq_t  q;
        int   e;
        rec_t r;
        q = ascii_123456789();
        q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        recs.delete();
        drive4(q, 1'b1, 1'b0, 1'b0, e);
        wait_done(1, "wide_done");
        get_rec(r);
        total++;
        if (r.cyc - e !== (APPEND ? 4 : 0)) begin
            bad++; $display("FAIL wide_done_latency got=%0d want=%0d", r.cyc - e, APPEND ? 4 : 0);
        end
        total++;
        if ({r.ok, r.len} !== {1'b1, 11'(APPEND ? 17 : 13)}) begin
            bad++; $display("FAIL wide_ok_len got=%h want=%h", {r.ok, r.len},
                            {1'b1, 11'(APPEND ? 17 : 13)});
        end
        total++;
        if ({r.crc, r.ok, r.le, r.len} !== model(q)) begin
            bad++; $display("FAIL wide_status got=%h want=%h", {r.crc, r.ok, r.le, r.len}, model(q));
        end
    endtask

    task automatic test_min_frame();
        bq_t  q;
        int   e;
        rec_t r;
        q = '{};
        for (int i = 0; i < 60; i++) q.push_back(8'h00);
        q = with_fcs(q);
        recs.delete();
        drive4(q, 1'b1, 1'b0, 1'b0, e);
        wait_done(1, "min_good_done");
        get_rec(r);
        total++;
        if ({r.ok, r.le} !== 2'b10) begin
            bad++; $display("FAIL min_good_flags got=%b want=10", {r.ok, r.le});
        end
        total++;
        if ({r.crc, r.ok, r.le, r.len} !== model(q)) begin
            bad++; $display("FAIL min_good_status got=%h want=%h", {r.crc, r.ok, r.le, r.len}, model(q));
        end
        q[10] = q[10] ^ 8'h01;
        drive4(q, 1'b1, 1'b0, 1'b0, e);
        wait_done(1, "min_bad_done");
        get_rec(r);
        total++;
        if ({r.crc, r.ok, r.le, r.len} !== model(q)) begin
            bad++; $display("FAIL min_bad_status got=%h want=%h", {r.crc, r.ok, r.le, r.len}, model(q));
        end
    endtask

    task automatic test_abort();
        bq_t  q1, q2;
        int   e;
        rec_t r;
        recs.delete();
        q1 = rand_bytes(20);
        q2 = with_fcs(rand_bytes(60));
        drive4(q1, 1'b0, 1'b0, 1'b0, e);
        drive4(q2, 1'b1, 1'b0, 1'b0, e);
        wait_done(1, "abort_done");
        idle4(10);
        total++;
        if (recs.size() !== 1) begin
            bad++; $display("FAIL abort_done_count got=%0d want=1", recs.size());
        end
        get_rec(r);
        total++;
        if ({r.crc, r.ok, r.le, r.len} !== model(q2) || r.ok !== 1'b1) begin
            bad++; $display("FAIL abort_status got=%h want=%h", {r.crc, r.ok, r.le, r.len}, model(q2));
        end
    endtask

    task automatic test_reset_mid();
        bq_t q;
        int  e;
        recs.delete();
        q = rand_bytes(24);
        drive4(q, 1'b0, 1'b0, 1'b0, e);
        @(negedge clk);
        v4 = 1'b0;
        #1;
        total++;
        if ({crc4, len4} !== {ref_fcs(q), 11'd24}) begin
            bad++; $display("FAIL midframe_running got=%h want=%h", {crc4, len4}, {ref_fcs(q), 11'd24});
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({r4, crc4, done4, ok4, le4, len4} !== {1'b1, 32'h0, 3'b000, 11'h0}) begin
            bad++;
            $display("FAIL midframe_reset got=%h want=%h", {r4, crc4, done4, ok4, le4, len4},
                     {1'b1, 32'h0, 3'b000, 11'h0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        // a continuation beat after reset has no frame to join
        @(negedge clk);
        v4 = 1'b1; s4 = 1'b0; e4 = 1'b1; k4 = 4'hF; d4 = $urandom;
        idle4(8);
        total++;
        if ({recs.size() == 0, len4} !== {1'b1, 11'h0}) begin
            bad++; $display("FAIL orphan_beat got=done_count %0d len %0d want=0 0", recs.size(), len4);
        end
    endtask

    task automatic test_giant();
        bq_t  q;
        int   e;
        rec_t r;
        q = with_fcs(rand_bytes(1515));
        recs.delete();
        drive4(q, 1'b1, 1'b0, 1'b1, e);
        wait_done(1, "giant_done");
        get_rec(r);
        total++;
        if ({r.crc, r.ok, r.le, r.len} !== model(q) || {r.ok, r.le} !== 2'b11) begin
            bad++; $display("FAIL giant_1519 got=%h want=%h", {r.crc, r.ok, r.le, r.len}, model(q));
        end
        q = rand_bytes(2100);
        drive4(q, 1'b1, 1'b0, 1'b0, e);
        wait_done(1, "giant2100_done");
        get_rec(r);
        total++;
        if ({r.crc, r.ok, r.le, r.len} !== model(q) || r.len !== 11'd2047) begin
            bad++; $display("FAIL giant_2100 got=%h want=%h", {r.crc, r.ok, r.le, r.len}, model(q));
        end
    endtask

    task automatic test_random();
        bq_t  q;
        int   e;
        bit   tail;
        rec_t r;
        for (int f = 0; f < 25; f++) begin
            q = rand_bytes($urandom_range(1, 160));
            if ($urandom_range(0, 1) == 1) q = with_fcs(q);
            tail = (q.size() % 4 == 0) && ($urandom_range(0, 1) == 1);
            recs.delete();
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                v4 = 1'b1; s4 = 1'b0; e4 = 1'($urandom); d4 = $urandom; k4 = 4'($urandom);
                wait_ready4();
            end
            drive4(q, 1'b1, tail, 1'b1, e);
            wait_done(1, "rand_done");
            get_rec(r);
            total++;
            if ({r.crc, r.ok, r.le, r.len} !== model(q)) begin
                bad++;
                $display("FAIL rand_frame%0d n=%0d got=%h want=%h", f, q.size(),
                         {r.crc, r.ok, r.le, r.len}, model(q));
            end
        end
    endtask

    task automatic test_back_to_back();
        bq_t  qa, qb;
        int   ea, eb;
        rec_t ra, rb;
        qa = with_fcs(rand_bytes(60));
        qb = rand_bytes(70);
        recs.delete();
        drive4(qa, 1'b1, 1'b0, 1'b0, ea);
        drive4(qb, 1'b1, 1'b0, 1'b0, eb);
        wait_done(2, "b2b_done");
        total++;
        if (eb - ea !== (APPEND ? 22 : 18)) begin
            bad++; $display("FAIL b2b_spacing got=%0d want=%0d", eb - ea, APPEND ? 22 : 18);
        end
        get_rec(ra);
        get_rec(rb);
        total++;
        if ({ra.crc, ra.ok, ra.le, ra.len} !== model(qa)) begin
            bad++; $display("FAIL b2b_first got=%h want=%h", {ra.crc, ra.ok, ra.le, ra.len}, model(qa));
        end
        total++;
        if ({rb.crc, rb.ok, rb.le, rb.len} !== model(qb) || rb.cyc - eb !== (APPEND ? 4 : 0)) begin
            bad++; $display("FAIL b2b_second got=%h want=%h", {rb.crc, rb.ok, rb.le, rb.len}, model(qb));
        end
    endtask

`ifdef FCS_CRC_APPEND_EN
    task automatic test_append();
        bq_t         q, got;
        int          e, t, hs_cyc;
        bit          ph, ready_bad, first_fv;
        logic [31:0] gb;
        rec_t        r;
        q = ascii_123456789();
        recs.delete();
        drive4(q, 1'b1, 1'b0, 1'b0, e);
        ph = 1'b1; ready_bad = 1'b0; first_fv = 1'b0; t = 0; hs_cyc = -1;
        while (got.size() < 4 && t < 40) begin
            @(negedge clk);
            v4 = 1'b0;
            fcs_ready = ph;
            ph = !ph;
            if (t == 0) first_fv = fv4;
            if (fv4 === 1'b1 && r4 !== 1'b0) ready_bad = 1'b1;
            if (fv4 === 1'b1 && fcs_ready) begin
                got.push_back(fb4);
                hs_cyc = cyc + 1;
            end
            t++;
        end
        wait_done(1, "append_done");
        fcs_ready = 1'b1;
        gb = (got.size() == 4) ? {got[0], got[1], got[2], got[3]} : 32'h0;
        total++;
        if (gb !== 32'h2639F4CB || first_fv !== 1'b1) begin
            bad++; $display("FAIL append_bytes got=%h want=2639f4cb", gb);
        end
        total++;
        if (ready_bad) begin
            bad++; $display("FAIL append_in_ready got=1 want=0");
        end
        get_rec(r);
        total++;
        if ({r.ok, r.len, r.cyc} !== {1'b1, 11'd13, hs_cyc}) begin
            bad++; $display("FAIL append_done got=%b %0d %0d want=1 13 %0d", r.ok, r.len, r.cyc, hs_cyc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_standard();
        test_wide_fcs();
        test_min_frame();
        test_abort();
        test_reset_mid();
        test_giant();
        test_random();
        test_back_to_back();
`ifdef FCS_CRC_APPEND_EN
        test_append();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
